cnt_down_timer: RTL and testbench
=================================

// Module: cnt_down_timer
// PURPOSE
//   Loadable down-counting timer. The free-running up-counter measures elapsed
//   cycles; this block is the other direction: it is given a count and runs it
//   out to zero.
//   - Counts from a loaded value to zero and signals expiry with a one-cycle done pulse.
//   - Supports pause, abort, restart and periodic auto-reload.
//   - Sits beside the up-counter as the timing source for seminar exercises.
// PARAMETERS
//   WIDTH     4  counter / load value width in bits
//   PRESCALE  4  clocks per decrement tick; used only when CNT_PRESCALE_EN is defined; must be >= 2
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      1-cycle request: load load_val and run
//   load_val     in   WIDTH  initial / reload count, sampled only when start=1
//   auto_reload  in   1      sampled with start; 1 = periodic mode
//   pause        in   1      level: while 1, the counter holds
//   abort        in   1      1-cycle request: stop, clear, no done
//   counter      out  WIDTH  current remaining count
//   busy         out  1      1 in RUN or HOLD
//   done         out  1      1-cycle expiry pulse (registered)
// BEHAVIOUR
//   - Reset: state=IDLE, counter=0, busy=0, done=0, reload register=0, auto flag=0.
//     rst overrides every other input, including mid-run.
//   - States: IDLE, RUN, HOLD. busy = (state != IDLE). All outputs are registered.
//   - Priority per edge: rst > abort > start > pause > decrement.
//   - IDLE:
//     - start with load_val != 0: counter <= load_val, reload reg <= load_val,
//       auto <= auto_reload, goto RUN.
//     - start with load_val == 0: done=1 for the next cycle, counter stays 0, stay IDLE.
//   - RUN:
//     - On each tick with counter > 1: counter <= counter - 1.
//     - On a tick with counter == 1: done <= 1.
//       - auto=0: counter <= 0, goto IDLE.
//       - auto=1: counter <= reload reg, stay RUN.
//     - pause=1: goto HOLD; counter is not decremented on that edge.
//   - HOLD: counter frozen; pause=0 returns to RUN, and decrementing resumes on the following tick.
//   - start in RUN or HOLD: restart with the new load_val and auto_reload, goto RUN.
//     A done due on the same edge is suppressed.
//   - abort in any state: counter <= 0, done <= 0, goto IDLE.
//   - Timing, no prescale: start sampled at edge E0, so counter = L after E0.
//     - Counter reaches 0 after edge E0+L; done is high in that same cycle.
//     - Auto-reload period = L cycles; counter never shows 0.
//   - done is 0 in every cycle except the single expiry cycle.
//   - Counter arithmetic is unsigned modulo 2^WIDTH. Underflow cannot occur:
//     the decrement is never applied at 0.
// CONFIGURATION
//   - Macro CNT_PRESCALE_EN:
//     - Defined: tick = 1 once every PRESCALE clocks. The prescaler clears on
//       rst, start and abort, and is frozen in HOLD and IDLE. Expiry comes
//       L*PRESCALE cycles after start.
//     - Not defined: tick = 1 on every clock, no prescaler logic is built, and
//       PRESCALE is ignored.
// STRUCTURE
//   - Shared header cnt_defs.vh:
//     - State encodings CNT_ST_IDLE=2'd0, CNT_ST_RUN=2'd1, CNT_ST_HOLD=2'd2.
//     - Default widths.
//   - Sub-module cnt_prescale (clk, rst, clr, en, tick), instantiated only under
//     CNT_PRESCALE_EN. All other logic is in cnt_down_timer.
// TESTING (macro undefined unless noted)
//   - Reset: rst=1 for 2 edges -> counter=0, busy=0, done=0; assert rst mid-run at
//     counter=5 -> next cycle counter=0, IDLE.
//   - One-shot: start, load_val=4 -> counter 4,3,2,1,0 on successive cycles;
//     done=1 only in the 0 cycle; busy falls with it.
//   - Auto-reload: load_val=3, auto_reload=1 -> counter 3,2,1,3,2,1; done each
//     time 1->3; abort -> counter=0, no done.
//   - Pause and restart:
//     - load_val=6, pause for 3 cycles at counter=4 -> 4 held 4 cycles, then resumes.
//     - start load_val=9 at counter=2 -> counter=9, no done.
//   - Corner: start with load_val=0 -> done=1 for 1 cycle, busy stays 0; load_val=15
//     -> done after exactly 15 cycles.
//   - CNT_PRESCALE_EN, PRESCALE=4, load_val=2 -> counter steps every 4 clocks;
//     done 8 cycles after start.

Source files
------------

// File: rtl/cnt_down_timer_pkg.sv
// Shared types and defaults for the loadable down-counting timer.
// State encoding is fixed so debug probes and checkers can decode state_o directly.
package cnt_down_timer_pkg;

  localparam int CNT_DEFAULT_WIDTH    = 4;
  localparam int CNT_DEFAULT_PRESCALE = 4;

  typedef enum logic [1:0] {
    CNT_ST_IDLE = 2'd0,
    CNT_ST_RUN  = 2'd1,
    CNT_ST_HOLD = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/cnt_down_timer_if.sv
// Control/status bundle of the down-counting timer.
// Requests (start, abort) are single-cycle pulses and pause is a level; there is no
// back-pressure, so every request is taken on the edge where it is seen.
interface cnt_down_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] counter;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, auto_reload, pause, abort,
    input  counter, busy, done
  );

  modport slave (
    input  start, load_val, auto_reload, pause, abort,
    output counter, busy, done
  );
endinterface

// File: rtl/cnt_down_timer_prescale.sv
// Tick divider for the timer: one tick every PRESCALE enabled clocks.
// Holding en low freezes the phase; clr restarts it from zero.
module cnt_prescale #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int            PW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer with pause, abort, restart and periodic auto-reload.
// Define CNT_PRESCALE_EN to decrement once every PRESCALE clocks instead of every clock.
module cnt_down_timer
  import cnt_down_timer_pkg::*;
#(
  parameter int WIDTH    = CNT_DEFAULT_WIDTH,
  parameter int PRESCALE = CNT_DEFAULT_PRESCALE
) (
  input  logic                      clk,
  input  logic                      rst,
  cnt_down_timer_if.slave           bus,
  output cnt_state_e                state_o
);
  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             auto_q, auto_d;
  logic             done_q, done_d;
  logic             tick;
  logic             last;
  logic             load_zero;

  assign last      = (counter_q == WIDTH'(1));
  assign load_zero = (bus.load_val == '0);

`ifdef CNT_PRESCALE_EN
  cnt_prescale #(.PRESCALE(PRESCALE)) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.start | bus.abort),
    .en   ((state_q == CNT_ST_RUN) && !bus.pause && !bus.start && !bus.abort),
    .tick (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CNT_ST_IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      auto_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      auto_q    <= auto_d;
      done_q    <= done_d;
    end
  end

  // Priority: abort > start > pause > decrement.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = CNT_ST_IDLE;
    end else if (bus.start) begin
      state_d = load_zero ? CNT_ST_IDLE : CNT_ST_RUN;
    end else begin
      case (state_q)
        CNT_ST_RUN: begin
          if (bus.pause)                    state_d = CNT_ST_HOLD;
          else if (tick && last && !auto_q) state_d = CNT_ST_IDLE;
        end
        CNT_ST_HOLD: if (!bus.pause) state_d = CNT_ST_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // A zero load counts nothing and expires at once, also when it restarts a run.
  always_comb begin
    counter_d = counter_q;
    reload_d  = reload_q;
    auto_d    = auto_q;
    done_d    = 1'b0;
    if (bus.abort) begin
      counter_d = '0;
    end else if (bus.start) begin
      if (load_zero) begin
        counter_d = '0;
        done_d    = 1'b1;
      end else begin
        counter_d = bus.load_val;
        reload_d  = bus.load_val;
        auto_d    = bus.auto_reload;
      end
    end else if ((state_q == CNT_ST_RUN) && !bus.pause && tick) begin
      if (last) begin
        done_d    = 1'b1;
        counter_d = auto_q ? reload_q : '0;
      end else begin
        counter_d = counter_q - WIDTH'(1);
      end
    end
  end

  assign bus.counter = counter_q;
  assign bus.busy    = (state_q != CNT_ST_IDLE);
  assign bus.done    = done_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_cnt_down_timer.sv
// Bench for cnt_down_timer: per-cycle comparison against a behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cnt_down_timer;
  import cnt_down_timer_pkg::*;

  localparam int WIDTH    = 4;
  localparam int PRESCALE = 4;

  logic       clk;
  logic       rst;
  cnt_state_e state_o;

  cnt_down_timer_if #(.WIDTH(WIDTH)) bus ();

  cnt_down_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt, m_reload, m_pre;
  bit m_busy, m_paused, m_auto, m_done, m_valid;

  initial begin
    m_cnt = 0; m_reload = 0; m_pre = 0;
    m_busy = 0; m_paused = 0; m_auto = 0; m_done = 0; m_valid = 0;
  end

  always @(posedge clk) begin
    bit tick;
    m_done = 0;
    if (rst) begin
      m_cnt = 0; m_reload = 0; m_pre = 0;
      m_busy = 0; m_paused = 0; m_auto = 0; m_valid = 1;
    end else if (bus.abort) begin
      m_cnt = 0; m_busy = 0; m_paused = 0; m_pre = 0;
    end else if (bus.start) begin
      m_pre = 0; m_paused = 0;
      if (bus.load_val == 0) begin
        m_cnt = 0; m_busy = 0; m_done = 1;
      end else begin
        m_cnt = bus.load_val; m_reload = bus.load_val;
        m_auto = bus.auto_reload; m_busy = 1;
      end
    end else if (m_busy && m_paused) begin
      if (!bus.pause) m_paused = 0;
    end else if (m_busy && bus.pause) begin
      m_paused = 1;
    end else if (m_busy) begin
`ifdef CNT_PRESCALE_EN
      tick  = (m_pre == PRESCALE - 1);
      m_pre = tick ? 0 : m_pre + 1;
`else
      tick = 1;
`endif
      if (tick) begin
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          m_done = 1;
          if (m_auto) m_cnt = m_reload;
          else begin m_cnt = 0; m_busy = 0; end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_counter", int'(bus.counter), m_cnt);
      chk("model_busy",    int'(bus.busy),    int'(m_busy));
      chk("model_done",    int'(bus.done),    int'(m_done));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_start(input int l, input bit a);
    bus.start = 1'b1; bus.load_val = WIDTH'(l); bus.auto_reload = a;
    cyc();
    bus.start = 1'b0; bus.auto_reload = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    rst = 1'b1;
    bus.start = 0; bus.load_val = '0; bus.auto_reload = 0; bus.pause = 0; bus.abort = 0;
    cyc(); cyc();
    chk("rst_counter", int'(bus.counter), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    cyc();

`ifndef CNT_PRESCALE_EN
    // one-shot 4,3,2,1,0
    do_start(4, 0);
    chk("os_c4", int'(bus.counter), 4);
    for (int v = 3; v >= 1; v--) begin
      cyc();
      chk("os_cnt", int'(bus.counter), v);
      chk("os_nodone", int'(bus.done), 0);
    end
    cyc();
    chk("os_c0", int'(bus.counter), 0);
    chk("os_done", int'(bus.done), 1);
    chk("os_busy_fall", int'(bus.busy), 0);
    cyc();
    chk("os_done_pulse", int'(bus.done), 0);

    // auto-reload 3,2,1,3,2,1,3 then abort
    do_start(3, 1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("ar_cnt", int'(bus.counter), (k % 3 == 2) ? 3 : 2 - (k % 3));
      chk("ar_done", int'(bus.done), (k % 3 == 2) ? 1 : 0);
    end
    do_abort();
    chk("abort_cnt", int'(bus.counter), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_busy", int'(bus.busy), 0);

    // pause at 4, then restart at 2
    do_start(6, 0);
    cyc(); cyc();
    chk("pz_c4", int'(bus.counter), 4);
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("pz_hold", int'(bus.counter), 4);
    end
    bus.pause = 1'b0;
    cyc();
    chk("pz_release", int'(bus.counter), 4);
    cyc();
    chk("pz_resume", int'(bus.counter), 3);
    cyc();
    chk("rs_c2", int'(bus.counter), 2);
    do_start(9, 0);
    chk("rs_c9", int'(bus.counter), 9);
    chk("rs_nodone", int'(bus.done), 0);
    do_abort();

    // zero load: immediate single done, never busy
    do_start(0, 0);
    chk("z_done", int'(bus.done), 1);
    chk("z_busy", int'(bus.busy), 0);
    chk("z_cnt", int'(bus.counter), 0);
    cyc();
    chk("z_done_off", int'(bus.done), 0);

    // full-scale load: done exactly 15 cycles after start
    do_start(15, 0);
    edges = 1;
    while (!bus.done && edges < 40) begin cyc(); edges++; end
    chk("full_latency", edges - 1, 15);

    // reset mid-run at counter 5
    do_start(8, 0);
    cyc(); cyc(); cyc();
    chk("mr_c5", int'(bus.counter), 5);
    rst = 1'b1;
    cyc();
    chk("mr_cnt", int'(bus.counter), 0);
    chk("mr_busy", int'(bus.busy), 0);
    rst = 1'b0;
    cyc();
`else
    // prescaled: load 2 steps every PRESCALE clocks, done 2*PRESCALE cycles after start
    do_start(2, 0);
    edges = 1;
    while (!bus.done && edges < 60) begin
      cyc(); edges++;
      if (edges == PRESCALE)     chk("ps_hold2", int'(bus.counter), 2);
      if (edges == PRESCALE + 1) chk("ps_step1", int'(bus.counter), 1);
    end
    chk("ps_latency", edges - 1, 2 * PRESCALE);
    chk("ps_cnt0", int'(bus.counter), 0);
    cyc();
`endif

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      bus.abort = ($urandom_range(0, 59) == 0);
      bus.start = ($urandom_range(0, 14) == 0);
      bus.load_val = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom_range(1, 15));
      bus.auto_reload = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
      cyc();
    end
    rst = 0; bus.abort = 0; bus.start = 0; bus.pause = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
